mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Sequences the analog multiplexer switcher: pulses its switch strobe, waits for analog settling, triggers one ADC conversion and forwards the channel-tagged sample downstream.
- Scans CH_PER_FRAME mux positions per frame, marks frame start and counts frames.
- Sits between the telemetry frame scheduler (enable/start) and the mux switcher plus ADC interface.

Parameters:
- CH_PER_FRAME, 18, mux positions per frame; one full switcher cycle; legal range 2..31.
- SWITCH_HOLD, 4, cycles switch_signal is held high, then held low; min 2.
- SETTLE_CYCLES, 64, cycles waited after the switch strobe before ADC start; min 1.
- ADC_W, 12, ADC sample width.
- ADC_TIMEOUT, 1024, cycles allowed for adc_done (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- scan_en  in  1  level; 1 = run continuous scanning.
- switch_signal  out  1  strobe to the mux switcher; one high/low pulse advances one position.
- adc_start  out  1  one-cycle conversion request.
- adc_done  in  1  one-cycle conversion-complete pulse.
- adc_data  in  ADC_W  sample; valid with adc_done.
- sample_data  out  ADC_W  held sample.
- sample_ch  out  5  channel index 0..CH_PER_FRAME-1 of sample_data.
- sample_sof  out  1  1 when sample_ch==0 (first sample of the frame).
- sample_err  out  1  sample produced by a timeout; data forced to 0.
- sample_valid  out  1  valid/ready handshake.
- sample_ready  in  1  downstream accept.
- frame_cnt  out  16  completed frames; wraps 0xFFFF->0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; channel counter 0; hold/settle counters 0.
- IDLE: leave when scan_en=1 on a clk edge -> SW_HI.
- SW_HI:
  - switch_signal=1 for exactly SWITCH_HOLD cycles -> SW_LO.
  - Also entered from IDLE; the switch pulse is always a full high then low pulse.
- SW_LO: switch_signal=0 for SWITCH_HOLD cycles -> SETTLE.
- SETTLE: wait SETTLE_CYCLES -> CONVERT; adc_start=1 for exactly one cycle on entry.
- CONVERT:
  - On adc_done: capture adc_data into sample_data, plus sample_ch = channel counter, sample_err=0 -> DELIVER.
  - adc_done in any other state is ignored.
- DELIVER:
  - sample_valid=1; sample_* are stable while valid and ready are not both 1.
  - On sample_valid & sample_ready, in the same edge:
    - valid -> 0.
    - Channel counter increments. At CH_PER_FRAME-1 it wraps to 0 and frame_cnt += 1.
    - Next state: SW_HI if scan_en=1, otherwise IDLE.
  - Backpressure: the sequencer stalls in DELIVER indefinitely; no sample is ever dropped.
- Latency:
  - From the first SW_HI cycle to adc_start: 2*SWITCH_HOLD + SETTLE_CYCLES cycles.
  - From adc_done to sample_valid=1: 1 cycle.
- scan_en=0 mid-scan: the current position completes (conversion and delivery), then IDLE. The channel counter is kept, so the next scan resumes at the next position, staying aligned with the switcher.
- scan_en toggling during SW_HI/SW_LO/SETTLE has no effect until DELIVER completes.
- Reset mid-operation: immediate return to the reset state. The switcher must be reset together with this block to keep channel alignment (system requirement, not checked here).

Optional Feature:
- Macro MUX_SCAN_TIMEOUT_EN.
- Defined:
  - CONVERT counts cycles. If ADC_TIMEOUT cycles elapse without adc_done, go to DELIVER with sample_data=0 and sample_err=1.
  - The channel advances normally, so the frame never stalls on a dead ADC.
  - adc_done arriving on the same cycle as the timeout wins: the real data is taken and err=0.
- Not defined: CONVERT waits forever; sample_err is tied to 0.

Test Plan:
- Basic scan: SWITCH_HOLD=4, SETTLE_CYCLES=64, scan_en=1, sample_ready=1, ADC replies 3 cycles after adc_start with data=ch*16 -> samples ch 0..17 with data 0x000..0x110; sample_sof=1 only on ch 0; frame_cnt=1 after the 18th; adc_start exactly 72 cycles after the SW_HI entry.
- Backpressure: sample_ready=0 for 100 cycles at ch 5 -> sample_valid stays 1 with data and ch constant; no switch_signal pulse until accept; ch 6 follows normally.
- Stop/resume: drop scan_en during SETTLE of ch 9 -> ch 9 is delivered, then IDLE with busy=0 and switch_signal=0; reassert -> next sample is ch 10.
- Wrap: run 65536 frames (force frame_cnt via a short-parameter build, CH_PER_FRAME=2) -> frame_cnt wraps 0xFFFF->0; the channel sequence is 0,1,0,1.
- Reset mid-CONVERT: assert reset -> all outputs 0 asynchronously; after release with scan_en=1, first sample ch=0, sof=1, frame_cnt=0.
- Timeout (macro defined, ADC_TIMEOUT=1024): no adc_done on ch 3 -> after 1024 cycles sample ch=3, err=1, data=0; ch 4 converts normally. With adc_done on cycle 1024 -> err=0 and the real data.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Drives the analog mux switcher and the ADC for one channel scan. Each
//   position is handled in this order:
//     1. switch strobe high for SWITCH_HOLD cycles, then low for SWITCH_HOLD
//     2. settle for SETTLE_CYCLES
//     3. one-cycle adc_start, then wait for adc_done
//     4. hold the channel-tagged sample on a valid/ready port until it is taken
//   After CH_PER_FRAME positions the channel index wraps to 0 and the frame
//   counter increments. The sequencer stalls in delivery under backpressure,
//   so no sample is ever dropped.
//
// Optional feature (macro MUX_SCAN_TIMEOUT_EN):
//   When defined, CONVERT gives up after ADC_TIMEOUT cycles and delivers a
//   zero sample with sample_err=1. When not defined, CONVERT waits for ever
//   and sample_err is tied low.
//
// Ports:
//   i_clk            system clock
//   i_reset          asynchronous reset, active low
//   i_scan_en        level; 1 = keep scanning
//   o_switch_signal  strobe to the mux switcher (one high/low pulse = one step)
//   o_adc_start      one-cycle conversion request
//   i_adc_done       one-cycle conversion-complete pulse
//   i_adc_data       ADC sample, valid with i_adc_done
//   o_sample_data    held sample
//   o_sample_ch      channel index of o_sample_data
//   o_sample_sof     first sample of a frame (channel 0)
//   o_sample_err     sample produced by a conversion timeout
//   o_sample_valid   sample handshake valid
//   i_sample_ready   sample handshake ready
//   o_frame_cnt      completed frames, wraps at 16 bits
//   o_busy           high whenever the sequencer is not idle
module mux_scan_sequencer #(
  parameter int CH_PER_FRAME  = 18,
  parameter int SWITCH_HOLD   = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int ADC_W         = 12,
  parameter int ADC_TIMEOUT   = 1024
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_scan_en,
  output logic             o_switch_signal,
  output logic             o_adc_start,
  input  logic             i_adc_done,
  input  logic [ADC_W-1:0] i_adc_data,
  output logic [ADC_W-1:0] o_sample_data,
  output logic [4:0]       o_sample_ch,
  output logic             o_sample_sof,
  output logic             o_sample_err,
  output logic             o_sample_valid,
  input  logic             i_sample_ready,
  output logic [15:0]      o_frame_cnt,
  output logic             o_busy
);

  // One shared phase counter covers hold, settle and (optionally) timeout.
  localparam int MAX_A = (SWITCH_HOLD > SETTLE_CYCLES) ? SWITCH_HOLD : SETTLE_CYCLES;
  localparam int MAX_C = (MAX_A > ADC_TIMEOUT) ? MAX_A : ADC_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] HOLD_M1   = CNT_W'(SWITCH_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       CH_M1     = 5'(CH_PER_FRAME - 1);
`ifdef MUX_SCAN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_M1    = CNT_W'(ADC_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SW_HI   = 3'd1,
    SW_LO   = 3'd2,
    SETTLE  = 3'd3,
    CONVERT = 3'd4,
    DELIVER = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [4:0]         r_ch;
  logic [15:0]        r_frame_cnt;
  logic               r_adc_start;
  logic [ADC_W-1:0]   r_sample_data;
  logic [4:0]         r_sample_ch;
  logic               r_sample_sof;
  logic               w_capture;
  logic               w_timeout;
  logic               w_accept;
  logic               w_ch_wrap;

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE:    if (i_scan_en)         w_state_nxt = SW_HI;
      SW_HI:   if (r_cnt == HOLD_M1)   w_state_nxt = SW_LO;
      SW_LO:   if (r_cnt == HOLD_M1)   w_state_nxt = SETTLE;
      SETTLE:  if (r_cnt == SETTLE_M1) w_state_nxt = CONVERT;
      CONVERT: begin
        // A real conversion arriving on the timeout cycle takes priority.
        if (i_adc_done) begin
          w_state_nxt = DELIVER;
          w_capture   = 1'b1;
        end
`ifdef MUX_SCAN_TIMEOUT_EN
        else if (r_cnt == TMO_M1) begin
          w_state_nxt = DELIVER;
          w_timeout   = 1'b1;
        end
`endif
      end
      DELIVER: begin
        if (i_sample_ready) begin
          w_accept    = 1'b1;
          // scan_en is only sampled here, so a stop request always lets the
          // current position finish first.
          w_state_nxt = i_scan_en ? SW_HI : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ch_wrap = (r_ch == CH_M1);

  //--------------------------------------------------------------------------
  // State, phase counter and conversion request
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_adc_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Counter restarts on every state change and idles at 0 where unused.
      if (w_state_nxt != r_state || r_state == IDLE || r_state == DELIVER)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      r_adc_start <= (r_state == SETTLE) && (w_state_nxt == CONVERT);
    end
  end

  //--------------------------------------------------------------------------
  // Channel and frame counters; advance only when a sample is accepted
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ch        <= '0;
      r_frame_cnt <= '0;
    end else if (w_accept) begin
      r_ch <= w_ch_wrap ? 5'd0 : r_ch + 5'd1;
      if (w_ch_wrap)
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  //--------------------------------------------------------------------------
  // Sample hold registers; loaded only on the way into DELIVER so they stay
  // stable for the whole handshake.
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sample_data <= '0;
      r_sample_ch   <= '0;
      r_sample_sof  <= 1'b0;
    end else if (w_capture || w_timeout) begin
      r_sample_data <= w_capture ? i_adc_data : '0;
      r_sample_ch   <= r_ch;
      r_sample_sof  <= (r_ch == 5'd0);
    end
  end

`ifdef MUX_SCAN_TIMEOUT_EN
  logic r_sample_err;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      r_sample_err <= 1'b0;
    else if (w_capture || w_timeout)
      r_sample_err <= w_timeout;
  end
  assign o_sample_err = r_sample_err;
`else
  assign o_sample_err = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign o_switch_signal = (r_state == SW_HI);
  assign o_adc_start     = r_adc_start;
  assign o_sample_valid  = (r_state == DELIVER);
  assign o_sample_data   = r_sample_data;
  assign o_sample_ch     = r_sample_ch;
  assign o_sample_sof    = r_sample_sof;
  assign o_frame_cnt     = r_frame_cnt;
  assign o_busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: basic scan, backpressure,
// stop/resume, async reset mid-conversion, frame counter wrap on a short
// build, and (when MUX_SCAN_TIMEOUT_EN is defined) the conversion timeout.
module tb_mux_scan_sequencer;
  localparam int CH = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        ready = 1'b1;
  logic        sw, adc_start, s_sof, s_err, s_valid, busy;
  logic [11:0] s_data;
  logic [4:0]  s_ch;
  logic [15:0] frame_cnt;

  // short build for the frame counter wrap
  logic        scan_en2 = 1'b0;
  logic        adc_done2 = 1'b0;
  logic [11:0] adc_data2 = 12'h0AB;
  logic        ready2 = 1'b1;
  logic        sw2, adc_start2, s_sof2, s_err2, s_valid2, busy2;
  logic [11:0] s_data2;
  logic [4:0]  s_ch2;
  logic [15:0] frame_cnt2;

  mux_scan_sequencer #(.CH_PER_FRAME(CH), .SWITCH_HOLD(4), .SETTLE_CYCLES(64),
                       .ADC_W(12), .ADC_TIMEOUT(1024)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_scan_en(scan_en),
    .o_switch_signal(sw), .o_adc_start(adc_start),
    .i_adc_done(adc_done), .i_adc_data(adc_data),
    .o_sample_data(s_data), .o_sample_ch(s_ch), .o_sample_sof(s_sof),
    .o_sample_err(s_err), .o_sample_valid(s_valid), .i_sample_ready(ready),
    .o_frame_cnt(frame_cnt), .o_busy(busy));

  mux_scan_sequencer #(.CH_PER_FRAME(2), .SWITCH_HOLD(2), .SETTLE_CYCLES(1),
                       .ADC_W(12), .ADC_TIMEOUT(1024)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_scan_en(scan_en2),
    .o_switch_signal(sw2), .o_adc_start(adc_start2),
    .i_adc_done(adc_done2), .i_adc_data(adc_data2),
    .o_sample_data(s_data2), .o_sample_ch(s_ch2), .o_sample_sof(s_sof2),
    .o_sample_err(s_err2), .o_sample_valid(s_valid2), .i_sample_ready(ready2),
    .o_frame_cnt(frame_cnt2), .o_busy(busy2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ADC model for the main DUT: replies adc_dly cycles after adc_start with
  // data = position*16, where position follows the switcher (mod CH).
  int mdl_ch   = 0;
  int adc_dly  = 3;
  bit adc_mute = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) mdl_ch = 0;
    else if (adc_start) begin
      int c;
      bit m;
      c = mdl_ch;
      m = adc_mute;
      mdl_ch = (mdl_ch + 1) % CH;
      repeat (adc_dly) begin
        @(posedge clk);
        #1;
      end
      if (!m) begin
        adc_done = 1'b1;
        adc_data = 12'(c * 16);
        @(posedge clk);
        #1;
        adc_done = 1'b0;
      end
    end
  end

  // ADC model for the short build: answers one cycle after adc_start.
  initial forever begin
    @(posedge clk);
    #1;
    adc_done2 = adc_start2;
  end

  task automatic wait_sample(input string tag, input int bound);
    int k = 0;
    while (!s_valid && k < bound) begin
      tick();
      k++;
    end
    if (!s_valid) chk(tag, {31'd0, s_valid}, 32'd1);
  endtask

  task automatic chk_sample(input int ch, input int data, input bit err);
    chk("smp_ch",   {27'd0, s_ch},   32'(ch));
    chk("smp_data", {20'd0, s_data}, 32'(data));
    chk("smp_sof",  {31'd0, s_sof},  32'(ch == 0));
    chk("smp_err",  {31'd0, s_err},  {31'd0, err});
  endtask

  initial begin
    int k;
    int c0;
    int bad;
    int exp_d;
    bit exp_e;

    // ---------------- reset state
    tick(3);
    chk("rst_ctl",   {26'd0, sw, adc_start, s_valid, s_sof, s_err, busy}, 32'd0);
    chk("rst_frame", {16'd0, frame_cnt}, 32'd0);
    chk("rst_data",  {20'd0, s_data}, 32'd0);
    chk("rst_ch",    {27'd0, s_ch}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // ---------------- basic scan, start latency
    scan_en = 1'b1;
    k = 0;
    while (!sw && k < 10) begin tick(); k++; end
    chk("sw_rise", {31'd0, sw}, 32'd1);
    c0 = cyc;
    k = 0;
    while (!adc_start && k < 200) begin tick(); k++; end
    chk("start_lat", 32'(cyc - c0), 32'd72);

    for (int i = 0; i < CH; i++) begin
      wait_sample("f1_wait", 2000);
      chk_sample(i, i * 16, 1'b0);
      tick();
    end
    chk("f1_frame", {16'd0, frame_cnt}, 32'd1);

    // ---------------- frame 2: backpressure at ch 5, stop/resume at ch 9
    for (int i = 0; i < CH; i++) begin
      if (i == 5) ready = 1'b0;
      if (i == 9) begin
        k = 0;
        while (!sw && k < 200) begin tick(); k++; end
        while (sw && k < 200) begin tick(); k++; end
        tick(14);              // 4 cycles of SW_LO, then 10 into SETTLE
        scan_en = 1'b0;
      end
      wait_sample("f2_wait", 2000);
      chk_sample(i, i * 16, 1'b0);
      if (i == 5) begin
        bad = 0;
        repeat (100) begin
          tick();
          if (!s_valid || s_data != 12'h050 || s_ch != 5'd5 || sw) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        ready = 1'b1;
      end
      tick();
      if (i == 9) begin
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_sw",   {31'd0, sw},   32'd0);
        tick(20);
        chk("stop_hold", {30'd0, busy, sw}, 32'd0);
        scan_en = 1'b1;
      end
    end
    chk("f2_frame", {16'd0, frame_cnt}, 32'd2);

    // ---------------- async reset during CONVERT of frame 3, ch 0
    k = 0;
    while (!adc_start && k < 200) begin tick(); k++; end
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_ctl",   {26'd0, sw, adc_start, s_valid, s_sof, s_err, busy}, 32'd0);
    chk("arst_frame", {16'd0, frame_cnt}, 32'd0);
    chk("arst_data",  {20'd0, s_data}, 32'd0);
    tick(10);
    rst_n = 1'b1;

    // ---------------- after reset; timeout cases when the feature is built
    for (int i = 0; i < 6; i++) begin
      exp_d = i * 16;
      exp_e = 1'b0;
`ifdef MUX_SCAN_TIMEOUT_EN
      if (i == 3) begin
        adc_mute = 1'b1;
        exp_d = 0;
        exp_e = 1'b1;
      end
      if (i == 5) adc_dly = 1023;   // done lands on the timeout cycle
`endif
      wait_sample("f4_wait", 1500);
      chk_sample(i, exp_d, exp_e);
      if (i == 0) chk("post_rst_frame", {16'd0, frame_cnt}, 32'd0);
      tick();
      adc_mute = 1'b0;
      adc_dly  = 3;
    end
    scan_en = 1'b0;

    // ---------------- frame counter wrap on the short build
    force u_dut2.r_frame_cnt = 16'hFFFF;
    tick();
    release u_dut2.r_frame_cnt;
    tick();
    chk("wrap_pre", {16'd0, frame_cnt2}, 32'h0000FFFF);
    scan_en2 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (!s_valid2 && k < 100) begin tick(); k++; end
      chk("wrap_valid", {31'd0, s_valid2}, 32'd1);
      chk("wrap_ch",    {27'd0, s_ch2}, 32'(j % 2));
      chk("wrap_data",  {20'd0, s_data2}, 32'h0AB);
      tick();
      if (j == 1) chk("wrap_frame0", {16'd0, frame_cnt2}, 32'd0);
      if (j == 3) chk("wrap_frame1", {16'd0, frame_cnt2}, 32'd1);
    end
    scan_en2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
